dual_core_mem_responder: RTL and testbench

- Shared main-memory responder for the dual-core MIPS system. It serves line-fill and write-through requests from the two per-core cache controllers over a req/ack handshake.
- Arbitrates round-robin between the two cores, models a fixed access latency, and owns the 2^ADDR_W-word backing store.
- On every completed write it broadcasts an invalidate to the other core's cache, which keeps the two caches coherent.

---
 rtl/mem_pkg.sv | 19 +
 rtl/dual_core_mem_responder_if.sv | 40 ++++
 rtl/mem_array.sv | 23 ++
 rtl/dual_core_mem_responder.sv | 110 +++++++++++
 tb/tb_dual_core_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the dual-core main-memory responder.
package mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic core_id_t;

  function automatic core_id_t other_core(input core_id_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/dual_core_mem_responder_if.sv
// Request/ack bus between the two cache controllers and the memory responder.
interface dual_core_mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              inv_valid;
  logic              inv_core;
  logic [ADDR_W-1:0] inv_addr;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  inv_valid, inv_core, inv_addr, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output inv_valid, inv_core, inv_addr, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read; rdata only updates when en is high.
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dual_core_mem_responder.sv
// Round-robin memory responder for two cores with fixed latency and
// write-invalidate broadcast to the non-writing core.
module dual_core_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  dual_core_mem_responder_if.slave bus
);

  state_t            state_q, state_d;
  core_id_t          ptr_q;
  core_id_t          gnt_q, gnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;

  logic              grant;
  logic              commit;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  logic              resp_ack0, resp_ack1, resp_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_q   <= gnt_d;
        we_q    <= gnt_d ? bus.we1    : bus.we0;
        addr_q  <= gnt_d ? bus.addr1  : bus.addr0;
        wdata_q <= gnt_d ? bus.wdata1 : bus.wdata0;
        cnt_q   <= 4'(LATENCY - 1);
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == RESP) ptr_q <= other_core(gnt_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    gnt_d     = ptr_q;
    commit    = 1'b0;
    resp_ack0 = 1'b0;
    resp_ack1 = 1'b0;
    resp_inv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant   = 1'b1;
          gnt_d   = (bus.req0 && bus.req1) ? ptr_q : core_id_t'(bus.req1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_ack0 = (gnt_q == 1'b0);
        resp_ack1 = (gnt_q == 1'b1);
        resp_inv  = we_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rst gating keeps an abort on the commit edge from touching the array.
  assign ram_en = commit && !rst;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_en && we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign bus.ack0      = resp_ack0;
  assign bus.ack1      = resp_ack1;
  assign bus.rdata0    = (resp_ack0 && !we_q) ? ram_rdata : '0;
  assign bus.rdata1    = (resp_ack1 && !we_q) ? ram_rdata : '0;
  assign bus.inv_valid = resp_inv;
  assign bus.inv_core  = resp_inv ? other_core(gnt_q) : 1'b0;
  assign bus.inv_addr  = resp_inv ? addr_q : '0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dual_core_mem_responder.sv
// Directed bench for dual_core_mem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dual_core_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dual_core_mem_responder_if #(.ADDR_W(12), .DATA_W(32)) b0 ();
  dual_core_mem_responder_if #(.ADDR_W(12), .DATA_W(32)) b1 ();

  dual_core_mem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  dual_core_mem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input bit d, input bit c);
    return d ? (c ? b1.ack1 : b1.ack0) : (c ? b0.ack1 : b0.ack0);
  endfunction
  function automatic logic [31:0] rdata_of(input bit d, input bit c);
    return d ? (c ? b1.rdata1 : b1.rdata0) : (c ? b0.rdata1 : b0.rdata0);
  endfunction
  function automatic logic inv_valid_of(input bit d);
    return d ? b1.inv_valid : b0.inv_valid;
  endfunction
  function automatic logic inv_core_of(input bit d);
    return d ? b1.inv_core : b0.inv_core;
  endfunction
  function automatic logic [11:0] inv_addr_of(input bit d);
    return d ? b1.inv_addr : b0.inv_addr;
  endfunction

  task automatic set_req(input bit d, input bit c, input logic v, input logic we,
                         input logic [11:0] a, input logic [31:0] w);
    if (!d && !c) begin b0.req0 = v; b0.we0 = we; b0.addr0 = a; b0.wdata0 = w; end
    if (!d &&  c) begin b0.req1 = v; b0.we1 = we; b0.addr1 = a; b0.wdata1 = w; end
    if ( d && !c) begin b1.req0 = v; b1.we0 = we; b1.addr0 = a; b1.wdata0 = w; end
    if ( d &&  c) begin b1.req1 = v; b1.we1 = we; b1.addr1 = a; b1.wdata1 = w; end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Single transaction on one core; call just after a rising edge with the DUT idle.
  task automatic txn(input bit d, input bit c, input logic we, input logic [11:0] a,
                     input logic [31:0] w, input logic [31:0] exp_rd, input int exp_k,
                     input string tag);
    bit got = 0;
    set_req(d, c, 1'b1, we, a, w);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack_of(d, c)) begin
        got = 1;
        chk({tag, "_lat"}, 64'(k), 64'(exp_k));
        chk({tag, "_rdata"}, 64'(rdata_of(d, c)), we ? 64'd0 : 64'(exp_rd));
        chk({tag, "_other_ack"}, 64'(ack_of(d, !c)), 64'd0);
        chk({tag, "_inv_valid"}, 64'(inv_valid_of(d)), 64'(we));
        if (we) begin
          chk({tag, "_inv_core"}, 64'(inv_core_of(d)), 64'(!c));
          chk({tag, "_inv_addr"}, 64'(inv_addr_of(d)), 64'(a));
        end
      end
    end
    if (!got) chk({tag, "_timeout"}, 64'd0, 64'd1);
    step();
    set_req(d, c, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  // Both cores request in the same cycle; core 0 expected to win.
  task automatic dual(input bit d,
                      input logic we0, input logic [11:0] a0, input logic [31:0] w0,
                      input logic we1, input logic [11:0] a1, input logic [31:0] w1,
                      input int exp_t0, input int exp_t1,
                      input logic [31:0] rd0, input logic [31:0] rd1, input string tag);
    int t0 = -1;
    int t1 = -1;
    bit s0, s1;
    set_req(d, 1'b0, 1'b1, we0, a0, w0);
    set_req(d, 1'b1, 1'b1, we1, a1, w1);
    for (int k = 0; k < 30 && t1 < 0; k++) begin
      @(negedge clk);
      s0 = ack_of(d, 1'b0);
      s1 = ack_of(d, 1'b1);
      chk({tag, "_onehot"}, 64'(s0 & s1), 64'd0);
      if (s0) begin
        t0 = k;
        chk({tag, "_rdata0"}, 64'(rdata_of(d, 1'b0)), we0 ? 64'd0 : 64'(rd0));
        chk({tag, "_inv0"}, 64'(inv_valid_of(d)), 64'(we0));
      end
      if (s1) begin
        t1 = k;
        chk({tag, "_rdata1"}, 64'(rdata_of(d, 1'b1)), we1 ? 64'd0 : 64'(rd1));
        chk({tag, "_inv1"}, 64'(inv_valid_of(d)), 64'(we1));
        if (we1) begin
          chk({tag, "_inv1_core"}, 64'(inv_core_of(d)), 64'd0);
          chk({tag, "_inv1_addr"}, 64'(inv_addr_of(d)), 64'(a1));
        end
      end
      step();
      if (s0) set_req(d, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
      if (s1) set_req(d, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    end
    chk({tag, "_t0"}, 64'(t0), 64'(exp_t0));
    chk({tag, "_t1"}, 64'(t1), 64'(exp_t1));
    set_req(d, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    set_req(d, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic reset0();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int n, last, iss0, iss1;
  bit exp_core, re0, re1, a0, a1, bad;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        set_req(d[0], c[0], 1'b0, 1'b0, 12'h000, 32'h0);
    step();
    step();
    rst = 1'b0;
    rst1 = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_ack0", 64'(b0.ack0), 64'd0);
    chk("rst_ack1", 64'(b0.ack1), 64'd0);
    chk("rst_rdata0", 64'(b0.rdata0), 64'd0);
    chk("rst_rdata1", 64'(b0.rdata1), 64'd0);
    chk("rst_inv", 64'({b0.inv_valid, b0.inv_core, b0.inv_addr}), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    step();
    rst = 1'b0;

    // 1: core 0 write then read, ack at c+3
    txn(1'b0, 1'b0, 1'b1, 12'h0A5, 32'hDEADBEEF, 32'h0, 3, "t1_wr");
    txn(1'b0, 1'b0, 1'b0, 12'h0A5, 32'h0, 32'hDEADBEEF, 3, "t1_rd");

    // 2: after reset, preload by core 1 (pointer back to 0), then simultaneous
    reset0();
    txn(1'b0, 1'b1, 1'b1, 12'h010, 32'h11111111, 32'h0, 3, "t2_pre");
    dual(1'b0, 1'b0, 12'h010, 32'h0, 1'b1, 12'h010, 32'h12345678,
         3, 7, 32'h11111111, 32'h0, "t2");
    txn(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 32'h12345678, 3, "t2_reread");

    // 3: sustained contention, 8 transactions
    reset0();
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 12'h0A5, 32'h0);
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
    iss0 = 1; iss1 = 1; n = 0; last = -1; exp_core = 0; re0 = 0; re1 = 0;
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(negedge clk);
      a0 = b0.ack0;
      a1 = b0.ack1;
      chk("t3_onehot", 64'(a0 & a1), 64'd0);
      if (a0 | a1) begin
        chk("t3_order", 64'(a1), 64'(exp_core));
        chk("t3_spacing", 64'(k - last), 64'd4);
        chk("t3_rdata", 64'(a1 ? b0.rdata1 : b0.rdata0),
            a1 ? 64'h12345678 : 64'hDEADBEEF);
        last = k;
        exp_core = !exp_core;
        n++;
      end
      step();
      if (re0) begin b0.req0 = 1'b1; iss0++; re0 = 0; end
      if (re1) begin b0.req1 = 1'b1; iss1++; re1 = 0; end
      if (a0) begin b0.req0 = 1'b0; re0 = (iss0 < 4); end
      if (a1) begin b0.req1 = 1'b0; re1 = (iss1 < 4); end
    end
    chk("t3_count", 64'(n), 64'd8);
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    step();

    // 4a: reset one cycle after the request, before the commit edge
    txn(1'b0, 1'b1, 1'b1, 12'h3FF, 32'h11111111, 32'h0, 3, "t4_pre");
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 12'h3FF, 32'hCAFEF00D);
    step();
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    chk("t4a_busy_before", 64'(b0.busy), 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4a_busy_after", 64'(b0.busy), 64'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (b0.ack1 || b0.inv_valid) bad = 1;
      @(negedge clk);
    end
    chk("t4a_no_ack_inv", 64'(bad), 64'd0);
    step();
    txn(1'b0, 1'b0, 1'b0, 12'h3FF, 32'h0, 32'h11111111, 3, "t4a_rd");

    // 4b: reset coincides with the commit edge
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 12'h3FF, 32'hCAFEF00D);
    step();
    step();
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    chk("t4b_busy_commit", 64'(b0.busy), 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4b_idle", 64'({b0.busy, b0.ack1, b0.inv_valid}), 64'd0);
    step();
    txn(1'b0, 1'b0, 1'b0, 12'h3FF, 32'h0, 32'h11111111, 3, "t4b_rd");

    // 5: cross-core coherence
    txn(1'b0, 1'b1, 1'b1, 12'h800, 32'h000000FF, 32'h0, 3, "t5_wr");
    txn(1'b0, 1'b0, 1'b0, 12'h800, 32'h0, 32'h000000FF, 3, "t5_rd");

    // 6: LATENCY=1 instance, ack at c+2, back-to-back spacing 3
    txn(1'b1, 1'b0, 1'b1, 12'h055, 32'hA5A5A5A5, 32'h0, 2, "t6_wr0");
    txn(1'b1, 1'b1, 1'b1, 12'h056, 32'h5A5A5A5A, 32'h0, 2, "t6_wr1");
    dual(1'b1, 1'b0, 12'h055, 32'h0, 1'b0, 12'h056, 32'h0,
         2, 5, 32'hA5A5A5A5, 32'h5A5A5A5A, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
